// File: rtl/overture_prog_loader.sv
// -----------------------------------------------------------------------------
// overture_prog_loader
//
// Program store and boot sequencer for the Overture CPU.
//
// It takes a byte stream over a valid/ready handshake and writes it into a
// 2**ADDR_W x 8 program RAM. The RAM is read combinationally at the CPU PC.
// It also sequences the CPU reset and run controls: load, then release, then
// either free-run or single-step.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   load_start  pulse: begin a load of load_len bytes (0 = rerun stored program)
//   load_len    byte count, ADDR_W+1 bits; values above 2**ADDR_W are clamped
//   in_valid    byte stream valid
//   in_data     byte stream data
//   in_ready    loader accepts a byte this cycle (high only in LOAD)
//   halt        level: abort load / stop CPU, return to IDLE
//   step_mode   1 = single-step while in RUN
//   step        pulse: one CPU cycle when step_mode=1 (edge-detected)
//   fetch_addr  CPU PC
//   fetch_data  instruction at fetch_addr (combinational)
//   cpu_reset   active-high synchronous reset to the CPU
//   cpu_run     CPU run enable
//   load_done   one-cycle pulse when the program is released
//   busy        sequencer not in IDLE
//
// States
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | CPU held in reset, waiting for load_start
//   ST_LOAD  | accepting bytes; remaining counts down to the terminal count
//   ST_PRIME | one-cycle release: load_done pulses, CPU still in reset
//   ST_RUN   | CPU out of reset; free-run or single-step
// -----------------------------------------------------------------------------
module overture_prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              halt,
  input  logic              step_mode,
  input  logic              step,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [7:0]        fetch_data,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic              load_done,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nx;
  logic [ADDR_W:0]   remaining, remaining_nx;
  logic [ADDR_W:0]   len_clamped;
  logic              mem_we;
  logic              step_q;
  logic              step_fire;

  logic [7:0] mem [DEPTH];

  assign len_clamped = (load_len > FULL_LEN) ? FULL_LEN : load_len;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      step_q    <= 1'b0;
      step_fire <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_ptr    <= wr_ptr_nx;
      remaining <= remaining_nx;
      step_q    <= step;
      // A step rising edge seen in RUN grants exactly one run cycle next.
      step_fire <= (state == ST_RUN) && step && !step_q;
    end
  end

  // Program RAM. Reset clears it so a partial load never survives reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Old value is visible during a same-cycle write to fetch_addr.
  assign fetch_data = mem[fetch_addr];

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx     = state;
    wr_ptr_nx    = wr_ptr;
    remaining_nx = remaining;
    mem_we       = 1'b0;
    in_ready     = 1'b0;
    cpu_reset    = 1'b1;
    cpu_run      = 1'b0;
    load_done    = 1'b0;
    busy         = 1'b1;

    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (load_start && !halt) begin
          if (load_len == '0) begin
            state_nx = ST_PRIME;
          end else begin
            state_nx     = ST_LOAD;
            wr_ptr_nx    = '0;
            remaining_nx = len_clamped;
          end
        end
      end

      ST_LOAD: begin
        in_ready = 1'b1;
        // halt wins over a concurrent handshake: that byte is dropped.
        if (halt) begin
          state_nx = ST_IDLE;
        end else if (in_valid) begin
          mem_we       = 1'b1;
          wr_ptr_nx    = wr_ptr + ADDR_W'(1);
          remaining_nx = remaining - (ADDR_W+1)'(1);
          if (remaining == (ADDR_W+1)'(1)) begin
            state_nx = ST_PRIME;
          end
        end
      end

      ST_PRIME: begin
        load_done = 1'b1;
        state_nx  = halt ? ST_IDLE : ST_RUN;
      end

      ST_RUN: begin
        cpu_reset = 1'b0;
        cpu_run   = step_mode ? step_fire : 1'b1;
        if (halt) begin
          state_nx = ST_IDLE;
        end else if (load_start) begin
          // A zero length from RUN reruns the stored program, same as IDLE,
          // rather than parking in LOAD with nothing to count down.
          if (load_len == '0) begin
            state_nx = ST_PRIME;
          end else begin
            state_nx     = ST_LOAD;
            wr_ptr_nx    = '0;
            remaining_nx = len_clamped;
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
